// File: rtl/proc_pkg.sv
// Shared processor types: memory-access FSM states and the execute-to-memory
// request bundle.
package proc_pkg;

    localparam int XLEN      = 32;
    localparam int REG_TAG_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_acc_state_t;

    typedef struct packed {
        logic                 we;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      wdata;
        logic [REG_TAG_W-1:0] rd;
    } mem_req_t;

endpackage

// File: rtl/mem_addr_check.sv
// Byte-address to word-index conversion with alignment check; the range check
// is enabled by MEM_ACCESS_BOUNDS_CHECK_EN, otherwise the index wraps.
module mem_addr_check #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 512
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       word_index,
    output logic              fault
);

    logic [ADDR_W-1:0] widx;

    assign widx = addr >> 2;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    assign word_index = 32'(widx);
    assign fault      = (addr[1:0] != 2'b00) ||
                        (widx >= ADDR_W'(MEM_WORDS));
`else
    assign word_index = 32'(widx % ADDR_W'(MEM_WORDS));
    assign fault      = (addr[1:0] != 2'b00);
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one outstanding load/store, fixed-latency data memory,
// traps misaligned (and, with MEM_ACCESS_BOUNDS_CHECK_EN, out-of-range) accesses.
module mem_access_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 512,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [REG_TAG_W-1:0] req_rd,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic [REG_TAG_W-1:0] resp_rd,
    output logic                 resp_fault,
    output logic                 mem_active,
    output logic                 mem_rw,
    output logic [31:0]          mem_index,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);

    mem_acc_state_t       state;
    logic [CW-1:0]        cnt;
    logic                 we_q;
    logic [REG_TAG_W-1:0] rd_q;
    mem_req_t             req;
    logic [31:0]          word_index;
    logic                 fault;

    assign req.we    = req_we;
    assign req.addr  = XLEN'(req_addr);
    assign req.wdata = XLEN'(req_wdata);
    assign req.rd    = req_rd;

    mem_addr_check #(
        .ADDR_W    (XLEN),
        .MEM_WORDS (MEM_WORDS)
    ) u_check (
        .addr       (req.addr),
        .word_index (word_index),
        .fault      (fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_fault <= 1'b0;
            mem_active <= 1'b0;
            mem_rw     <= 1'b0;
            mem_index  <= '0;
            mem_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req.we;
                        rd_q      <= req.rd;
                        // Trapped accesses skip the memory entirely.
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                            resp_rd    <= req.rd;
                        end else begin
                            state      <= ISSUE;
                            mem_active <= 1'b1;
                            mem_rw     <= req.we;
                            mem_index  <= word_index;
                            mem_wdata  <= DATA_W'(req.wdata);
                        end
                    end
                end
                ISSUE: begin
                    mem_active <= 1'b0;
                    mem_rw     <= 1'b0;
                    mem_index  <= '0;
                    mem_wdata  <= '0;
                    cnt        <= CW'(MEM_LAT - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rd    <= rd_q;
                        resp_rdata <= we_q ? '0 : mem_rdata;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_rd    <= '0;
                        resp_fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage between execute and writeback in the single-cycle-issue processor. Accepts one load/store request at a time over a valid/ready handshake and converts the byte address to a word index. Drives the data memory's `active`/`rw`/`index`/`inputMem` inputs for exactly one cycle, waits a fixed memory latency, captures read data and returns a tagged response to writeback. Misaligned and out-of-range accesses are trapped here and never reach the memory.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data width
- `MEM_WORDS`, 512, data-memory depth in words
- `MEM_LAT`, 1, cycles from the memory's sampling edge to valid `mem_rdata` (≥1)
- `clk  in  1  clock, all state on rising edge`
- `rst_n  in  1  reset, asynchronous assert, active-low`
- `req_valid  in  1  request present`
- `req_ready  out  1  stage can accept a request`
- `req_we  in  1  1 = store, 0 = load`
- `req_addr  in  ADDR_W  byte address`
- `req_wdata  in  DATA_W  store data`
- `req_rd  in  5  destination register tag`
- `resp_valid  out  1  response present`
- `resp_ready  in  1  writeback accepts response`
- `resp_rdata  out  DATA_W  load data; 0 for stores and faults`
- `resp_rd  out  5  echoed tag`
- `resp_fault  out  1  access trapped`
- `mem_active  out  1  memory enable`
- `mem_rw  out  1  1 = write, 0 = read`
- `mem_index  out  32  word index`
- `mem_wdata  out  DATA_W  write data`
- `mem_rdata  in  DATA_W  memory read data`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: `req_ready`=1; all other outputs 0.
- IDLE: `req_ready`=1. On `req_valid`, the stage latches `we`, `addr`, `wdata` and `rd`.
  - If `addr[1:0]`≠0, the access is a fault: go to RESP with `resp_fault`=1 and `resp_rdata`=0.
  - Otherwise go to ISSUE.
- ISSUE lasts one cycle. `mem_active`=1, `mem_rw`=we, `mem_index`=addr>>2, `mem_wdata`=wdata. Next state is WAIT; the latency counter loads MEM_LAT-1.
- WAIT: the counter decrements each cycle. At count 0, capture `mem_rdata` for loads (0 for stores) and go to RESP.
- RESP: `resp_valid`=1. Data, tag and fault are held stable until `resp_ready`. On the handshake, go to IDLE.
- `req_ready` is 0 in every state except IDLE. There is one outstanding access at most, and requests are never dropped or reordered.
- Memory outputs are registered and equal 0 outside ISSUE. `mem_active` is never high for more than one consecutive cycle.
- Counter width is `$clog2(MEM_LAT+1)`.

## Timing
- Request accepted at the edge ending cycle N.
- Normal access: ISSUE in N+1, WAIT in N+2 … N+1+MEM_LAT, `resp_valid` from N+2+MEM_LAT. Default latency is 3 cycles.
- Fault: `resp_valid` from N+1. No memory cycle occurs.
- Throughput: 1 request per MEM_LAT+3 cycles with `resp_ready` tied high.
- Back-pressure: `resp_valid` stays high and the payload stays stable while `resp_ready`=0.
- `req_ready` returns to 1 in the cycle after the response handshake. There is no same-cycle accept.
- Reset mid-operation: asynchronous return to IDLE, and `mem_active` drops immediately.
  - A store whose ISSUE cycle completed before reset is committed in memory; one interrupted before its edge is not.
  - No response is emitted for an aborted request.

## Configuration
- `MEM_ACCESS_BOUNDS_CHECK_EN` defined: a word index ≥ MEM_WORDS is a fault. It is handled like a misaligned access (RESP at N+1, no memory cycle).
- Not defined: `mem_index` = (addr>>2) modulo MEM_WORDS. Accesses wrap silently and are never faulted for range.

## Structure
- Shared package `proc_pkg` holds:
  - the state enum `mem_acc_state_t`
  - the constant `REG_TAG_W`=5
  - a `mem_req_t` struct (we, addr, wdata, rd) that this stage and execute both use
- One sub-module, `mem_addr_check`: combinational alignment and bounds check producing `word_index` and `fault`. It contains the only code affected by the macro.

## Test plan
- Store 0xDEADBEEF to 0x8, then load 0x8 → load `resp_rdata`=0xDEADBEEF with tag echoed. Store response has `resp_rdata`=0 and `resp_fault`=0. `mem_index`=2 during ISSUE. `resp_valid` arrives 3 cycles after accept.
- Load 0x6 (misaligned) → `resp_fault`=1 at N+1; `mem_active` never asserts.
- Load with `resp_ready` held low 4 cycles → payload stable, `req_ready`=0 throughout, one handshake only.
- Load 0x800 (word 512):
  - with the macro → fault, no memory cycle;
  - without it → `mem_index`=0 and the data of word 0 is returned.
- Back-to-back requests with `req_valid` held high → second accept exactly one cycle after the first response handshake; `mem_active` pulses once per request.
- `rst_n` low during WAIT of a load → all outputs 0 at once, `req_ready`=1 after release, no `resp_valid` for the aborted load.
